// File: rtl/freq_meter_mc.sv
// Multi-channel edge-rate meter: counts synchronised rising edges per channel over a common gate window.
// Optional macro FREQ_METER_RANGE_CHK_EN adds per-channel LO_LIM/HI_LIM range checking (CH_RANGE_ERR).
module freq_meter_mc #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int GATE_W   = 32,
    parameter int GATE_DEF = 50000000,
    parameter int SYNC_STG = 3
) (
    input  logic                     CLK_50M,
    input  logic                     RST_N,
    input  logic                     ENABLE,
    input  logic [GATE_W-1:0]        GATE_LEN,
    input  logic [NUM_CH-1:0]        SIG_IN,
`ifdef FREQ_METER_RANGE_CHK_EN
    input  logic [NUM_CH*CNT_W-1:0]  LO_LIM,
    input  logic [NUM_CH*CNT_W-1:0]  HI_LIM,
    output logic [NUM_CH-1:0]        CH_RANGE_ERR,
`endif
    output logic [NUM_CH*CNT_W-1:0]  FREQ_CNT,
    output logic                     CNT_VALID,
    output logic [NUM_CH-1:0]        CH_ALIVE,
    output logic [NUM_CH-1:0]        CH_OVF,
    output logic                     BUSY
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [GATE_W-1:0] GATE_DEF_V = GATE_W'(GATE_DEF);

    state_t            state_q, state_d;
    logic [GATE_W-1:0] gate_len_q, gate_len_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic              valid_q, valid_d;
    logic [GATE_W-1:0] sample_len;
    logic              terminal;
    logic              counting;

    assign sample_len = (GATE_LEN == '0) ? GATE_DEF_V : GATE_LEN;
    assign terminal   = (state_q == S_RUN) && (gate_cnt_q == gate_len_q - GATE_W'(1));
    // Counters only advance inside a window that continues past this cycle.
    assign counting   = (state_q == S_RUN) && !terminal && ENABLE;

    always_comb begin
        state_d    = state_q;
        gate_len_d = gate_len_q;
        gate_cnt_d = gate_cnt_q;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    gate_len_d = sample_len;
                    gate_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (terminal) begin
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    gate_len_d = sample_len;
                    if (!ENABLE) state_d = S_IDLE;
                end else if (!ENABLE) begin
                    gate_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            gate_len_q <= '0;
            gate_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_len_q <= gate_len_d;
            gate_cnt_q <= gate_cnt_d;
            valid_q    <= valid_d;
        end
    end

    assign CNT_VALID = valid_q;
    assign BUSY      = (state_q == S_RUN);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [SYNC_STG-1:0] sync_q, sync_d;
            logic                hist_q, hist_d;
            logic [CNT_W-1:0]    cnt_q, cnt_d;
            logic                ovf_q, ovf_d;
            logic [CNT_W-1:0]    freq_q, freq_d;
            logic                alive_q, alive_d;
            logic                ch_ovf_q, ch_ovf_d;
            logic                edge_det;
            logic                at_max;
            logic [CNT_W-1:0]    cnt_fin;
            logic                ovf_fin;

            assign edge_det = sync_q[SYNC_STG-1] & ~hist_q;
            assign at_max   = (cnt_q == CNT_MAX);
            // Value the window would close with if it ended this cycle (includes this cycle's edge).
            assign cnt_fin  = (edge_det && !at_max) ? cnt_q + CNT_W'(1) : cnt_q;
            assign ovf_fin  = ovf_q | (edge_det & at_max);

            always_comb begin
                sync_d   = {sync_q[SYNC_STG-2:0], SIG_IN[gi]};
                hist_d   = sync_q[SYNC_STG-1];
                cnt_d    = '0;
                ovf_d    = 1'b0;
                freq_d   = freq_q;
                alive_d  = alive_q;
                ch_ovf_d = ch_ovf_q;
                if (counting) begin
                    cnt_d = cnt_fin;
                    ovf_d = ovf_fin;
                end
                if (terminal) begin
                    freq_d   = cnt_fin;
                    alive_d  = (cnt_fin != '0);
                    ch_ovf_d = ovf_fin;
                end
            end

            always_ff @(posedge CLK_50M or negedge RST_N) begin
                if (!RST_N) begin
                    sync_q   <= '0;
                    hist_q   <= 1'b0;
                    cnt_q    <= '0;
                    ovf_q    <= 1'b0;
                    freq_q   <= '0;
                    alive_q  <= 1'b0;
                    ch_ovf_q <= 1'b0;
                end else begin
                    sync_q   <= sync_d;
                    hist_q   <= hist_d;
                    cnt_q    <= cnt_d;
                    ovf_q    <= ovf_d;
                    freq_q   <= freq_d;
                    alive_q  <= alive_d;
                    ch_ovf_q <= ch_ovf_d;
                end
            end

            assign FREQ_CNT[gi*CNT_W +: CNT_W] = freq_q;
            assign CH_ALIVE[gi]                = alive_q;
            assign CH_OVF[gi]                  = ch_ovf_q;

`ifdef FREQ_METER_RANGE_CHK_EN
            logic             rerr_q, rerr_d;
            logic [CNT_W-1:0] lo_lim;
            logic [CNT_W-1:0] hi_lim;

            assign lo_lim = LO_LIM[gi*CNT_W +: CNT_W];
            assign hi_lim = HI_LIM[gi*CNT_W +: CNT_W];

            always_comb begin
                rerr_d = rerr_q;
                if (terminal) rerr_d = (cnt_fin < lo_lim) | (cnt_fin > hi_lim) | ovf_fin;
            end

            always_ff @(posedge CLK_50M or negedge RST_N) begin
                if (!RST_N) rerr_q <= 1'b0;
                else        rerr_q <= rerr_d;
            end

            assign CH_RANGE_ERR[gi] = rerr_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed bench for freq_meter_mc: 4 channels, 8-bit counters, GATE_DEF reduced to 200 cycles.
module tb_freq_meter_mc;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int GW  = 16;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [GW-1:0]     gate_len;
    logic [NCH-1:0]    sig_in;
    logic [NCH*CW-1:0] freq_cnt;
    logic              cnt_valid;
    logic [NCH-1:0]    ch_alive;
    logic [NCH-1:0]    ch_ovf;
    logic              busy;
`ifdef FREQ_METER_RANGE_CHK_EN
    logic [NCH*CW-1:0] lo_lim;
    logic [NCH*CW-1:0] hi_lim;
    logic [NCH-1:0]    ch_range_err;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int per [NCH];
    logic lvl [NCH];

    freq_meter_mc #(
        .NUM_CH(NCH), .CNT_W(CW), .GATE_W(GW), .GATE_DEF(200), .SYNC_STG(3)
    ) dut (
        .CLK_50M(clk),
        .RST_N(rst_n),
        .ENABLE(enable),
        .GATE_LEN(gate_len),
        .SIG_IN(sig_in),
`ifdef FREQ_METER_RANGE_CHK_EN
        .LO_LIM(lo_lim),
        .HI_LIM(hi_lim),
        .CH_RANGE_ERR(ch_range_err),
`endif
        .FREQ_CNT(freq_cnt),
        .CNT_VALID(cnt_valid),
        .CH_ALIVE(ch_alive),
        .CH_OVF(ch_ovf),
        .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strictly periodic stimulus: period P gives exactly L/P edges in any L-cycle window when P divides L.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < NCH; k++)
            sig_in[k] = (per[k] == 0) ? lvl[k] : ((cyc % per[k]) < (per[k] / 2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cnt_valid && n < max);
        chk("valid_seen", {31'd0, cnt_valid}, 32'd1);
    endtask

    function automatic logic [CW-1:0] fc(input int k);
        return freq_cnt[k*CW +: CW];
    endfunction

    initial begin
        int n;
        int pulses;
        rst_n    = 1'b0;
        enable   = 1'b0;
        gate_len = '0;
        per[0] = 10; per[1] = 4; per[2] = 0; per[3] = 0;
        lvl[0] = 1'b0; lvl[1] = 1'b0; lvl[2] = 1'b0; lvl[3] = 1'b1;
`ifdef FREQ_METER_RANGE_CHK_EN
        lo_lim = {8'd0, 8'd0, 8'd0, 8'd90};
        hi_lim = {8'd255, 8'd255, 8'd255, 8'd110};
`endif

        // Reset with inputs toggling, then idle
        repeat (10) tick();
        chk("rst_freq", freq_cnt, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, cnt_valid}, 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (500) begin
            tick();
            if (cnt_valid) pulses++;
        end
        chk("idle_no_valid", pulses, 32'd0);
        chk("idle_freq", freq_cnt, 32'd0);
        chk("idle_flags", {24'd0, ch_alive, ch_ovf}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Basic count, L=1000
        gate_len = 16'd1000;
        enable   = 1'b1;
        tick();
        chk("run_busy", {31'd0, busy}, 32'd1);
        wait_valid(1100, n);
        chk("first_latency", n + 1, 32'd1001);
        chk("basic_freq", freq_cnt, {8'd0, 8'd0, 8'd250, 8'd100});
        chk("basic_alive", {28'd0, ch_alive}, 32'd3);
        chk("basic_ovf", {28'd0, ch_ovf}, 32'd0);
`ifdef FREQ_METER_RANGE_CHK_EN
        chk("range_in", {28'd0, ch_range_err}, 32'd0);
`endif
        tick();
        chk("valid_one_cycle", {31'd0, cnt_valid}, 32'd0);
        wait_valid(1100, n);
        chk("second_period", n + 1, 32'd1000);
        chk("basic_freq2", freq_cnt, {8'd0, 8'd0, 8'd250, 8'd100});

        // Default gate (200) with GATE_LEN written to 50 mid-window
        enable = 1'b0;
        tick();
        chk("drop_busy", {31'd0, busy}, 32'd0);
        gate_len = '0;
        enable   = 1'b1;
        repeat (100) tick();
        gate_len = 16'd50;
        wait_valid(300, n);
        chk("default_window", n + 100, 32'd201);
        chk("default_freq", freq_cnt, {8'd0, 8'd0, 8'd50, 8'd20});
        wait_valid(300, n);
        chk("short_window", n, 32'd50);
        chk("short_ch0", fc(0), 32'd5);
        wait_valid(300, n);
        chk("short_ch0_again", fc(0), 32'd5);

        // Saturation: 300 edges into an 8-bit counter
        gate_len = 16'd1200;
        per[0] = 4;
        per[1] = 8;
        wait_valid(300, n);
        wait_valid(1300, n);
        chk("sat_window", n, 32'd1200);
        chk("sat_freq", freq_cnt, {8'd0, 8'd0, 8'd150, 8'd255});
        chk("sat_ovf", {28'd0, ch_ovf}, 32'd1);
        chk("sat_alive", {28'd0, ch_alive}, 32'd3);
`ifdef FREQ_METER_RANGE_CHK_EN
        chk("range_ovf", {28'd0, ch_range_err}, 32'd1);
`endif
        per[0]   = 0;
        gate_len = 16'd200;
        wait_valid(1300, n);
        wait_valid(300, n);
        chk("stop_window", n, 32'd200);
        chk("stop_freq", freq_cnt, {8'd0, 8'd0, 8'd25, 8'd0});
        chk("stop_ovf", {28'd0, ch_ovf}, 32'd0);
        chk("stop_alive", {28'd0, ch_alive}, 32'd2);

        // ENABLE drop at gate count 500, then re-enable
        per[0]   = 10;
        gate_len = 16'd1000;
        wait_valid(300, n);
        wait_valid(1100, n);
        chk("pre_drop_freq", freq_cnt, {8'd0, 8'd0, 8'd125, 8'd100});
        repeat (500) tick();
        enable = 1'b0;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        repeat (1100) begin
            tick();
            if (cnt_valid) pulses++;
        end
        chk("abort_no_valid", pulses, 32'd0);
        chk("abort_hold", freq_cnt, {8'd0, 8'd0, 8'd125, 8'd100});
        enable = 1'b1;
        wait_valid(1100, n);
        chk("reenable_latency", n, 32'd1001);
        chk("reenable_freq", freq_cnt, {8'd0, 8'd0, 8'd125, 8'd100});

        // Reset mid-window clears outputs at once
        repeat (300) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_freq", freq_cnt, 32'd0);
        chk("midrst_flags", {23'd0, busy, ch_alive, ch_ovf}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_valid(1100, n);
        chk("postrst_latency", n, 32'd1001);
        chk("postrst_ch2", fc(2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freq_meter_mc.md
Name: freq_meter_mc

Overview:
- Multi-channel frequency/edge-rate meter in the CLK_50M domain.
- Each channel synchronises an asynchronous input (clock divided down, PLL lock tick, encoder, etc.), counts rising edges over a common programmable gate window, and publishes per-channel counts once per window.
- Generalises the single-channel period detector: N channels, parametric widths, runtime gate length, saturation/overflow and dead-channel flags, enable control.
- Sits beside the clock/status monitors; results are read by the register block.

Parameters:
- NUM_CH, 4, number of measured channels.
- CNT_W, 32, width of each edge counter and result.
- GATE_W, 32, width of gate length and gate counter.
- GATE_DEF, 50000000, gate length in CLK_50M cycles used when GATE_LEN==0 (default gives 1 s, so count = Hz).
- SYNC_STG, 3, synchroniser flops per channel (legal 2..4).

Ports:
- CLK_50M  in  1  single clock for the whole block.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  high = measure continuously, low = stop and hold results.
- GATE_LEN  in  GATE_W  gate length in cycles; 0 selects GATE_DEF; sampled at window start only.
- SIG_IN  in  NUM_CH  asynchronous inputs to measure.
- FREQ_CNT  out  NUM_CH*CNT_W  per-channel edge count of the last completed window; channel k at [k*CNT_W +: CNT_W].
- CNT_VALID  out  1  one-cycle pulse when FREQ_CNT updates.
- CH_ALIVE  out  NUM_CH  bit k=1 if channel k count of the last window is non-zero.
- CH_OVF  out  NUM_CH  bit k=1 if channel k saturated in the last window.
- BUSY  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release): FREQ_CNT=0, CNT_VALID=0, CH_ALIVE=0, CH_OVF=0, BUSY=0; synchronisers, edge history, counters and gate counter cleared; state=IDLE.
- Synchroniser: SYNC_STG flops per channel. Edge detect compares the last synchroniser flop with a history flop; a rising edge is counted for one cycle.
- Input constraint: high and low phases must each last at least 2 CLK_50M cycles. Faster inputs alias and are not detected.
- State IDLE: BUSY=0, edge counters held at 0, and the history flop tracks the synced level every cycle. This prevents a spurious edge on entry to RUN. When ENABLE=1 in cycle t:
  - gate length L is latched (GATE_LEN, or GATE_DEF if GATE_LEN is 0);
  - gate counter is set to 0;
  - the block moves to RUN at cycle t+1.
- State RUN: BUSY=1. Gate counter increments each cycle. Each channel counter increments on each detected edge.
- Counter saturation: a counter stops at 2^CNT_W-1. A sticky per-window overflow bit is set if an edge arrives while the counter is saturated.
- Terminal cycle (gate counter == L-1, first reached at cycle t+L):
  - next cycle FREQ_CNT[k] = counter + edge-this-cycle, saturated; CH_OVF and CH_ALIVE are updated; CNT_VALID=1 for one cycle;
  - in the same cycle counters and overflow bits clear and gate counter returns to 0;
  - GATE_LEN is re-sampled, so the new length applies to the next window.
- Windows run back-to-back with no gap. An edge in the terminal cycle belongs to the closing window.
- L==1 is legal: CNT_VALID pulses every cycle.
- ENABLE=0 in RUN: next cycle go to IDLE. The partial window is discarded, no CNT_VALID, and outputs hold the last published values. If ENABLE falls in the terminal cycle, that window still publishes.
- GATE_LEN changes mid-window are ignored until the next window start.
- Reset mid-window: immediate clear to reset values, no publish.
- Frequency for software: f_k = FREQ_CNT[k] * 50e6 / L.

Optional Feature:
- Macro FREQ_METER_RANGE_CHK_EN.
- When defined:
  - adds input ports LO_LIM and HI_LIM (NUM_CH*CNT_W each, same channel slicing);
  - adds output CH_RANGE_ERR (NUM_CH), updated with CNT_VALID;
  - bit k = 1 if published FREQ_CNT[k] < LO_LIM[k], or > HI_LIM[k], or CH_OVF[k]=1;
  - limits are sampled in the terminal cycle; reset value is 0.
- When undefined: ports absent, no comparator logic, all other behaviour identical.

Test Plan:
- Reset/idle: hold RST_N=0 with SIG_IN toggling, then release with ENABLE=0 for 500 cycles -> all outputs 0, no CNT_VALID.
- Basic count: GATE_LEN=1000; ch0 period 10 clk, ch1 period 4 clk, ch2 constant 0, ch3 constant 1; assert ENABLE at cycle t ->
  - CNT_VALID first pulses at t+1001, then every 1000 cycles;
  - FREQ_CNT = {0, 0, 250, 100} (ch3..ch0) ±1 for phase;
  - CH_ALIVE=4'b0011, CH_OVF=0.
- Default gate and mid-window change: GATE_LEN=0, GATE_DEF overridden to 200; write GATE_LEN=50 mid-window ->
  - current window still 200 cycles;
  - following windows 50 cycles, ch0 count 5.
- Saturation: CNT_W=8, GATE_LEN=1000, ch0 period 2 clk... → aliasing case.
  - Use instead period 4 clk (250 edges) with CNT_W=7 -> FREQ_CNT[0]=127, CH_OVF[0]=1.
  - The next window with ch0 stopped -> 0, CH_OVF cleared.
- ENABLE drop and reset mid-window:
  - deassert ENABLE at gate count 500 -> BUSY falls next cycle, no CNT_VALID, previous FREQ_CNT held;
  - re-enable -> full window before the next publish;
  - pulsing RST_N at gate count 300 clears all outputs immediately.
- FREQ_METER_RANGE_CHK_EN: LO_LIM[0]=90, HI_LIM[0]=110, ch0 period 10 clk (count 100) -> CH_RANGE_ERR[0]=0; change to period 5 clk (count 200) -> CH_RANGE_ERR[0]=1 at next CNT_VALID.
